multibyte_add_seq: RTL and testbench
====================================

MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, the operand width in bytes (legal 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block uses only this clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition.
REQ-005 SHALL have port a_in  input  8*NBYTES  operand A.
REQ-006 SHALL have port b_in  input  8*NBYTES  operand B.
REQ-007 SHALL have port cin  input  1  carry-in of the whole addition.
REQ-008 SHALL have ports add_a, add_b  output  8  byte operands driven to the external 8-bit ripple-carry adder.
REQ-009 SHALL have port add_cin  output  1  carry driven to the adder.
REQ-010 SHALL have ports add_sum  input  8, add_cout  input  1  combinational adder result.
REQ-011 SHALL have port busy  output  1  high while bytes are being added.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports sum_out  output  8*NBYTES, cout_out  output  1  final result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL, in IDLE with start=1 at an edge, latch a_in, b_in, set carry register to cin, set byte index to 0, clear sum_out and cout_out, and enter RUN.
REQ-016 SHALL, in RUN, drive add_a/add_b with byte[index] of the latched operands (byte 0 = bits 7:0) and add_cin with the carry register; otherwise drive add_a, add_b and add_cin as 0.
REQ-017 SHALL, at each RUN edge, write add_sum into sum_out byte[index], load add_cout into the carry register, and increment the index.
REQ-018 SHALL, at the RUN edge where index = NBYTES-1, load cout_out with add_cout and enter DONE.
REQ-019 SHALL assert done only in DONE, i.e. high exactly NBYTES edges after the edge that accepted start, for one cycle, then return to IDLE.
REQ-020 SHALL assert busy in RUN only; busy=0 in IDLE and DONE.
REQ-021 SHALL ignore start in RUN and DONE, with no effect on the latched operands or the result.
REQ-022 SHALL hold sum_out and cout_out stable from DONE until the next accepted start.
REQ-023 SHALL produce the result sum_out = (A+B+cin) mod 2^(8*NBYTES), with cout_out as the carry out of bit 8*NBYTES-1; wrap-around is not an error.
REQ-024 SHALL treat operand changes on a_in/b_in after acceptance as having no effect.

Reset
REQ-025 SHALL, with rst=1 at an edge, force IDLE, index 0, carry 0, sum_out 0, cout_out 0, busy 0, done 0.
REQ-026 SHALL give rst priority over start; reset during RUN aborts the operation and produces no done pulse.

Configuration
REQ-027 SHALL, with macro MBADD_OVF_EN defined, add port ovf_out  output  1  signed overflow: 1 when A and B MSBs are equal and the sum MSB differs, loaded with cout_out and reset to 0.
REQ-028 SHALL, without MBADD_OVF_EN, have no ovf_out port and no overflow logic.

Verification (NBYTES=4, adder model attached)
REQ-029 SHALL cover: A=0x000000FF, B=0x00000001, cin=0 -> done 4 edges after start, sum_out=0x00000100, cout_out=0.
REQ-030 SHALL cover: A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum_out=0x00000000, cout_out=1 (wrap).
REQ-031 SHALL cover: A=0, B=0, cin=1 -> sum_out=0x00000001, cout_out=0; busy high for exactly 4 cycles.
REQ-032 SHALL cover: start pulsed again during RUN with different operands -> the first result is unchanged and only one done pulse occurs.
REQ-033 SHALL cover: rst asserted on the 2nd RUN cycle -> the next cycle shows busy=0, sum_out=0, and no done pulse.
REQ-034 SHALL cover, with MBADD_OVF_EN: A=0x7FFFFFFF, B=0x00000001 -> sum_out=0x80000000, ovf_out=1, cout_out=0.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// Byte-serial adder sequencer: feeds one byte pair per cycle to an external 8-bit adder.
// Optional signed-overflow output ovf_out is enabled by defining MBADD_OVF_EN.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a_in,
  input  logic [8*NBYTES-1:0]   b_in,
  input  logic                  cin,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  busy,
  output logic                  done,
`ifdef MBADD_OVF_EN
  output logic                  ovf_out,
`endif
  output logic [8*NBYTES-1:0]   sum_out,
  output logic                  cout_out
);

  localparam int unsigned IdxW = $clog2(NBYTES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [NBYTES-1:0][7:0] a_q, a_d;
  logic [NBYTES-1:0][7:0] b_q, b_d;
  logic [NBYTES-1:0][7:0] sum_q, sum_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic                   cout_q, cout_d;
`ifdef MBADD_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun:  if (idx_q == LastIdx) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: adder operands are only driven while a byte is in flight
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    unique case (state_q)
      StRun: begin
        busy    = 1'b1;
        add_a   = a_q[idx_q];
        add_b   = b_q[idx_q];
        add_cin = carry_q;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef MBADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef MBADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      StRun: begin
        sum_d[idx_q] = add_sum;
        carry_d      = add_cout;
        idx_d        = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          cout_d = add_cout;
`ifdef MBADD_OVF_EN
          // Same-sign operands whose top sum bit flips sign overflow
          ovf_d  = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                   (add_sum[7] != a_q[NBYTES-1][7]);
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef MBADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef MBADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum_out  = sum_q;
  assign cout_out = cout_q;
`ifdef MBADD_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq (NBYTES=4) with a behavioural 8-bit adder.
module tb_multibyte_add_seq;

  localparam int unsigned NB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [8*NB-1:0] a_in, b_in;
  logic            cin;
  logic [7:0]      add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic            busy, done;
  logic [8*NB-1:0] sum_out;
  logic            cout_out;
`ifdef MBADD_OVF_EN
  logic            ovf_out;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // External ripple-carry adder model
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin      (cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
`ifdef MBADD_OVF_EN
    .ovf_out  (ovf_out),
`endif
    .sum_out  (sum_out),
    .cout_out (cout_out)
  );

  // Launch one addition and watch a bounded window after the accepting edge
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                       output logic [31:0] s, output logic co, output int lat,
                       output int busy_cnt, output int done_cnt);
    s = 'x;
    co = 1'bx;
    lat = -1;
    busy_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    a_in = a;
    b_in = b;
    cin = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = i;
        s = sum_out;
        co = cout_out;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a_in = '0;
    b_in = '0;
    cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++;
    if (sum_out !== 32'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum_out); end
    checks++;
    if ({add_a, add_b, add_cin, cout_out} !== 18'h0) begin
      failures++;
      $display("FAIL reset_adder_bus got=%h/%h/%b cout=%b exp=0", add_a, add_b, add_cin, cout_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_carry_chain();
    logic [31:0] s;
    logic co;
    int lat, bc, dc;
    // Check adder bus on the first two RUN cycles
    @(negedge clk);
    a_in = 32'h0000_00FF;
    b_in = 32'h0000_0001;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if ({add_a, add_b, add_cin} !== {8'hFF, 8'h01, 1'b0}) begin
      failures++;
      $display("FAIL bus_byte0 got=%h/%h/%b exp=ff/01/0", add_a, add_b, add_cin);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({add_a, add_b, add_cin} !== {8'h00, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL bus_byte1 got=%h/%h/%b exp=00/00/1", add_a, add_b, add_cin);
    end
    repeat (4) @(posedge clk);
    #1;
    // Full-timing run of the same vector
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, s, co, lat, bc, dc);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d exp=4", lat); end
    checks++;
    if (s !== 32'h0000_0100) begin failures++; $display("FAIL carry_sum got=%h exp=00000100", s); end
    checks++;
    if (co !== 1'b0) begin failures++; $display("FAIL carry_cout got=%b exp=0", co); end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL carry_done_pulses got=%0d exp=1", dc); end
  endtask

  task automatic test_wrap();
    logic [31:0] s;
    logic co;
    int lat, bc, dc;
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, co, lat, bc, dc);
    checks++;
    if (s !== 32'h0000_0000) begin failures++; $display("FAIL wrap_sum got=%h exp=00000000", s); end
    checks++;
    if (co !== 1'b1) begin failures++; $display("FAIL wrap_cout got=%b exp=1", co); end
  endtask

  task automatic test_cin();
    logic [31:0] s;
    logic co;
    int lat, bc, dc;
    do_op(32'h0, 32'h0, 1'b1, s, co, lat, bc, dc);
    checks++;
    if (s !== 32'h0000_0001) begin failures++; $display("FAIL cin_sum got=%h exp=00000001", s); end
    checks++;
    if (co !== 1'b0) begin failures++; $display("FAIL cin_cout got=%b exp=0", co); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL cin_busy_cycles got=%0d exp=4", bc); end
  endtask

  task automatic test_start_ignored();
    int dc;
    dc = 0;
    @(negedge clk);
    a_in = 32'h1234_5678;
    b_in = 32'h1111_1111;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    // New request and new operands while RUN/DONE must be ignored
    a_in = 32'hFFFF_FFFF;
    b_in = 32'hFFFF_FFFF;
    cin = 1'b1;
    start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dc++;
      if (i == 4) start = 1'b0;
    end
    checks++;
    if (dc !== 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d exp=1", dc); end
    checks++;
    if (sum_out !== 32'h2345_6789) begin
      failures++;
      $display("FAIL ignore_sum got=%h exp=23456789", sum_out);
    end
    checks++;
    if (cout_out !== 1'b0) begin failures++; $display("FAIL ignore_cout got=%b exp=0", cout_out); end
  endtask

  task automatic test_reset_abort();
    int dc;
    dc = 0;
    @(negedge clk);
    a_in = 32'h0000_00FE;
    b_in = 32'h0000_0001;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (sum_out !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL abort_partial_sum got=%h exp=000000ff", sum_out);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++;
    if (sum_out !== 32'h0) begin failures++; $display("FAIL abort_sum got=%h exp=0", sum_out); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) dc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dc !== 0) begin failures++; $display("FAIL abort_done_pulses got=%0d exp=0", dc); end
  endtask

`ifdef MBADD_OVF_EN
  task automatic test_ovf();
    logic [31:0] s;
    logic co;
    int lat, bc, dc;
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, co, lat, bc, dc);
    checks++;
    if (s !== 32'h8000_0000) begin failures++; $display("FAIL ovf_sum got=%h exp=80000000", s); end
    checks++;
    if (co !== 1'b0) begin failures++; $display("FAIL ovf_cout got=%b exp=0", co); end
    checks++;
    if (ovf_out !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf_out); end
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, s, co, lat, bc, dc);
    checks++;
    if (ovf_out !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_wrap();
    test_cin();
    test_start_ignored();
    test_reset_abort();
`ifdef MBADD_OVF_EN
    test_ovf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=expired exp=finished");
    $fatal(1, "timeout");
  end

endmodule
